// File: rtl/uart_in_mux.sv
// UART -> USB multiplexer: buffers one byte per UART channel, round-robin arbitrates,
// and writes each byte to the USB FIFO as an (index, value) record. Optional: UART_IN_OVERRUN_EN.
module uart_in_mux #(
  parameter int DATA_BITS  = 8,
  parameter int UART_COUNT = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [UART_COUNT-1:0]           read,
  input  logic [UART_COUNT*DATA_BITS-1:0] data,
  input  logic                            fifo_full,
  output logic                            fifo_write,
  output logic [DATA_BITS-1:0]            fifo_data
);

  localparam int IW = (UART_COUNT > 1) ? $clog2(UART_COUNT) : 1;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WRITE_INDEX = 2'd1;
  localparam logic [1:0] WRITE_VALUE = 2'd2;

  logic [1:0]            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         index_q;
  logic [DATA_BITS-1:0]  value_q;
  logic [UART_COUNT-1:0] pending;
  logic [DATA_BITS-1:0]  hold [UART_COUNT];

  logic                  grant_valid;
  logic [IW-1:0]         grant;
  logic                  grant_fire;
  logic [UART_COUNT-1:0] grant_mask;
  logic [IW-1:0]         next_ptr;
  logic [DATA_BITS-1:0]  index_word;

  // Round-robin search: the lowest pending channel at or above ptr wins; if none,
  // wrap and take the lowest pending channel overall.
  logic          hi_valid;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_valid    = 1'b0;
    hi_idx      = '0;
    grant_valid = 1'b0;
    lo_idx      = '0;
    for (int i = UART_COUNT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_valid = 1'b1;
        lo_idx      = IW'(i);
        if (i >= int'(ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    grant = hi_valid ? hi_idx : lo_idx;
  end

  assign grant_fire = (state == IDLE) && grant_valid;
  assign next_ptr   = (int'(grant) == UART_COUNT - 1) ? '0 : grant + 1'b1;

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < UART_COUNT; i++) begin
      grant_mask[i] = grant_fire && (IW'(i) == grant);
    end
  end

  // NOTE: holding registers carry no reset; a byte is only ever consumed while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < UART_COUNT; i++) begin
      if (read[i]) begin
        hold[i] <= data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // A strobe on the channel being granted re-arms pending: the old byte was snapshotted above.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | read;
    end
  end

`ifdef UART_IN_OVERRUN_EN
  logic [UART_COUNT-1:0] lost;
  logic                  lost_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost   <= '0;
      lost_q <= 1'b0;
    end else begin
      lost <= (lost & ~grant_mask) | (read & pending & ~grant_mask);
      if (grant_fire) begin
        lost_q <= lost[grant];
      end
    end
  end

  always_comb begin
    index_word             = '0;
    index_word[IW-1:0]     = index_q;
    index_word[7]          = lost_q;
  end
`else
  always_comb begin
    index_word         = '0;
    index_word[IW-1:0] = index_q;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      index_q <= '0;
      value_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            index_q <= grant;
            value_q <= hold[grant];
            ptr     <= next_ptr;
            state   <= WRITE_INDEX;
          end
        end
        WRITE_INDEX: begin
          if (!fifo_full) begin
            state <= WRITE_VALUE;
          end
        end
        WRITE_VALUE: begin
          if (!fifo_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state, so a stalled word stays stable on fifo_data.
  assign fifo_write = (state != IDLE) && !fifo_full;

  always_comb begin
    case (state)
      WRITE_INDEX: fifo_data = index_word;
      WRITE_VALUE: fifo_data = value_q;
      default:     fifo_data = '0;
    endcase
  end

endmodule
